// File: rtl/reg_pkg.sv
// Shared register-file definitions: widths, special register indices and
// the writeback entry type. The register file and its write-side queue
// both import this package.
package reg_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_ADR_W = 6;
    localparam int unsigned PC_IDX    = 32;
    localparam int unsigned REG_ZERO  = 0;

    typedef struct packed {
        logic [REG_ADR_W-1:0] adr;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // True for an index the queue may store: not the zero register and
    // below the PC slot.
    function automatic logic is_gpr_idx(input int unsigned idx);
        return (idx != REG_ZERO) && (idx < PC_IDX);
    endfunction

    // True for the PC slot and anything above it.
    function automatic logic is_pc_or_above(input int unsigned idx);
        return idx >= PC_IDX;
    endfunction

endpackage

// File: rtl/reg_wb_queue_fwd_lookup.sv
// Forwarding lookup over the writeback queue: finds the youngest valid
// entry whose address matches the lookup address. Purely combinational.
module reg_wb_fwd_lookup #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ADR_W = 6
) (
    input  logic [ADR_W-1:0]         i_adr [DEPTH],
    input  logic [XLEN-1:0]          i_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] i_head,
    input  logic [$clog2(DEPTH):0]   i_count,
    input  logic [ADR_W-1:0]         i_radr,
    output logic                     o_hit,
    output logic [XLEN-1:0]          o_data
);
    import reg_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic            w_hit;
    logic [XLEN-1:0] w_data;

    // Walk from oldest (head) to youngest; a later match overwrites an
    // earlier one so the entry closest to the tail wins. Slots beyond the
    // live count are ignored, and the zero register / PC slot never hit.
    always_comb begin
        w_hit  = 1'b0;
        w_data = '0;
        if (is_gpr_idx(32'(i_radr))) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((CNT_W'(k) < i_count) &&
                    (i_adr[i_head + PTR_W'(k)] == i_radr)) begin
                    w_hit  = 1'b1;
                    w_data = i_data[i_head + PTR_W'(k)];
                end
            end
        end
    end

    assign o_hit  = w_hit;
    assign o_data = w_data;

endmodule

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the register file write port. Buffers
// retiring results, writes at most one per cycle in arrival order, and
// offers decode a youngest-match forwarding view of everything still
// queued. The PC slot is never written from here.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = reg_pkg::XLEN,
    parameter int ADR_W = reg_pkg::REG_ADR_W
) (
    input  logic             clk,
    input  logic             reset,
    // Producer side
    input  logic             WB_VALID_RE,
    output logic             WB_READY_SW,
    input  logic [ADR_W-1:0] WB_ADR_RE,
    input  logic [XLEN-1:0]  WB_DATA_RE,
    // Register file write port
    input  logic             DRAIN_EN_SD,
    output logic [XLEN-1:0]  WDATA_SW,
    output logic [ADR_W-1:0] WADR_SW,
    output logic             WENABLE_SW,
    // Decode forwarding lookup
    input  logic [ADR_W-1:0] RADR1_SD,
    input  logic [ADR_W-1:0] RADR2_SD,
    output logic             FWD_HIT1_SW,
    output logic [XLEN-1:0]  FWD_DATA1_SW,
    output logic             FWD_HIT2_SW,
    output logic [XLEN-1:0]  FWD_DATA2_SW,
    // Status
    output logic             DROP_ERR_SW,
    output logic             EMPTY_SW
);
    import reg_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; only slots between head and head+count are live.
    logic [ADR_W-1:0] r_adr  [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_drop_err;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_pop;

    // Handshake: a transfer happens on a rising edge where WB_VALID_RE and
    // WB_READY_SW are both high. WB_READY_SW comes from registered
    // occupancy only, so it never depends on WB_VALID_RE or DRAIN_EN_SD in
    // the same cycle; the producer holds address/data stable while valid
    // is high and ready is low.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_accept = WB_VALID_RE && !w_full;

    // Register 0 is silently consumed, the PC slot and above are consumed
    // and flagged, everything else is queued.
    assign w_push = w_accept && is_gpr_idx(32'(WB_ADR_RE));
    assign w_drop = w_accept && is_pc_or_above(32'(WB_ADR_RE));

    // The head is written whenever something is queued and drain is allowed.
    assign w_pop = !w_empty && DRAIN_EN_SD;

    assign WB_READY_SW = !w_full;
    assign WENABLE_SW  = w_pop;
    assign WADR_SW     = w_empty ? '0 : r_adr[r_head];
    assign WDATA_SW    = w_empty ? '0 : r_data[r_head];
    assign EMPTY_SW    = w_empty;
    assign DROP_ERR_SW = r_drop_err;

    // Store an accepted legal result at the tail slot. Data slots carry no
    // reset: a slot is only observed once the count covers it.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_adr[r_tail]  <= WB_ADR_RE;
            r_data[r_tail] <= WB_DATA_RE;
        end
    end

    // Pointer, occupancy and drop-flag update; reset wins over any
    // transfer or drain in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_drop_err <= w_drop;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    reg_wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ADR_W (ADR_W)
    ) u_fwd1 (
        .i_adr   (r_adr),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_radr  (RADR1_SD),
        .o_hit   (FWD_HIT1_SW),
        .o_data  (FWD_DATA1_SW)
    );

    reg_wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ADR_W (ADR_W)
    ) u_fwd2 (
        .i_adr   (r_adr),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_radr  (RADR2_SD),
        .o_hit   (FWD_HIT2_SW),
        .o_data  (FWD_DATA2_SW)
    );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. A write-port monitor
// compares every register-file write against the expected queue.
module tb_reg_wb_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int ADR_W = 6;
    localparam int W     = ADR_W + XLEN;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             WB_VALID_RE;
    logic             WB_READY_SW;
    logic [ADR_W-1:0] WB_ADR_RE;
    logic [XLEN-1:0]  WB_DATA_RE;
    logic             DRAIN_EN_SD;
    logic [XLEN-1:0]  WDATA_SW;
    logic [ADR_W-1:0] WADR_SW;
    logic             WENABLE_SW;
    logic [ADR_W-1:0] RADR1_SD;
    logic [ADR_W-1:0] RADR2_SD;
    logic             FWD_HIT1_SW;
    logic [XLEN-1:0]  FWD_DATA1_SW;
    logic             FWD_HIT2_SW;
    logic [XLEN-1:0]  FWD_DATA2_SW;
    logic             DROP_ERR_SW;
    logic             EMPTY_SW;

    reg_wb_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ADR_W (ADR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .WB_VALID_RE  (WB_VALID_RE),
        .WB_READY_SW  (WB_READY_SW),
        .WB_ADR_RE    (WB_ADR_RE),
        .WB_DATA_RE   (WB_DATA_RE),
        .DRAIN_EN_SD  (DRAIN_EN_SD),
        .WDATA_SW     (WDATA_SW),
        .WADR_SW      (WADR_SW),
        .WENABLE_SW   (WENABLE_SW),
        .RADR1_SD     (RADR1_SD),
        .RADR2_SD     (RADR2_SD),
        .FWD_HIT1_SW  (FWD_HIT1_SW),
        .FWD_DATA1_SW (FWD_DATA1_SW),
        .FWD_HIT2_SW  (FWD_HIT2_SW),
        .FWD_DATA2_SW (FWD_DATA2_SW),
        .DROP_ERR_SW  (DROP_ERR_SW),
        .EMPTY_SW     (EMPTY_SW)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && WENABLE_SW === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'({WADR_SW, WDATA_SW}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_port", 64'({WADR_SW, WDATA_SW}), 64'(mon_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic offer(input logic [ADR_W-1:0] a, input logic [XLEN-1:0] d);
        WB_VALID_RE = 1'b1;
        WB_ADR_RE   = a;
        WB_DATA_RE  = d;
    endtask

    task automatic idle();
        WB_VALID_RE = 1'b0;
        WB_ADR_RE   = '0;
        WB_DATA_RE  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        DRAIN_EN_SD = 1'b0;
        RADR1_SD    = '0;
        RADR2_SD    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset       = 1'b0;
        DRAIN_EN_SD = 1'b1;
        RADR1_SD    = 6'd5;
        RADR2_SD    = 6'd6;

        // Reset state
        mid();
        check("rst_wen",   64'(WENABLE_SW),   64'd0);
        check("rst_wadr",  64'(WADR_SW),      64'd0);
        check("rst_wdata", 64'(WDATA_SW),     64'd0);
        check("rst_hit1",  64'(FWD_HIT1_SW),  64'd0);
        check("rst_data1", 64'(FWD_DATA1_SW), 64'd0);
        check("rst_hit2",  64'(FWD_HIT2_SW),  64'd0);
        check("rst_data2", 64'(FWD_DATA2_SW), 64'd0);
        check("rst_drop",  64'(DROP_ERR_SW),  64'd0);
        check("rst_empty", 64'(EMPTY_SW),     64'd1);
        check("rst_ready", 64'(WB_READY_SW),  64'd1);

        // Single write, one-cycle latency to the write port
        tick();
        offer(6'd5, 32'hDEADBEEF);
        exp_q.push_back({6'd5, 32'hDEADBEEF});
        mid();
        check("t1_ready",        64'(WB_READY_SW), 64'd1);
        check("t1_offered_nohit", 64'(FWD_HIT1_SW), 64'd0);
        tick();
        idle();
        mid();
        check("t1_wen",   64'(WENABLE_SW),   64'd1);
        check("t1_wadr",  64'(WADR_SW),      64'd5);
        check("t1_wdata", 64'(WDATA_SW),     64'hDEADBEEF);
        check("t1_hit1_head", 64'(FWD_HIT1_SW),  64'd1);
        check("t1_data1_head", 64'(FWD_DATA1_SW), 64'hDEADBEEF);
        tick();
        mid();
        check("t1_empty_after", 64'(EMPTY_SW),   64'd1);
        check("t1_wen_after",   64'(WENABLE_SW), 64'd0);

        // Fill and backpressure
        tick();
        DRAIN_EN_SD = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            offer(ADR_W'(i), XLEN'(32'h11 * i));
            exp_q.push_back({ADR_W'(i), XLEN'(32'h11 * i)});
            tick();
        end
        offer(6'd6, 32'h66);
        exp_q.push_back({6'd6, 32'h66});
        mid();
        check("t2_full_ready", 64'(WB_READY_SW), 64'd0);
        check("t2_hold_wen",   64'(WENABLE_SW),  64'd0);
        check("t2_full_empty", 64'(EMPTY_SW),    64'd0);
        tick();
        DRAIN_EN_SD = 1'b1;
        mid();
        check("t2_drain_ready", 64'(WB_READY_SW), 64'd0);
        check("t2_drain_wadr",  64'(WADR_SW),     64'd1);
        tick();
        mid();
        check("t2_ready_after_drain", 64'(WB_READY_SW), 64'd1);
        tick();
        idle();
        repeat (3) tick();
        mid();
        check("t2_empty_end", 64'(EMPTY_SW), 64'd1);

        // Forwarding youngest-wins
        tick();
        DRAIN_EN_SD = 1'b0;
        RADR1_SD    = 6'd7;
        RADR2_SD    = 6'd0;
        offer(6'd7, 32'h1);
        exp_q.push_back({6'd7, 32'h1});
        mid();
        check("t3_offer_excluded", 64'(FWD_HIT1_SW), 64'd0);
        tick();
        offer(6'd7, 32'h2);
        exp_q.push_back({6'd7, 32'h2});
        mid();
        check("t3_one_queued_hit",  64'(FWD_HIT1_SW),  64'd1);
        check("t3_one_queued_data", 64'(FWD_DATA1_SW), 64'h1);
        tick();
        idle();
        mid();
        check("t3_hit1",  64'(FWD_HIT1_SW),  64'd1);
        check("t3_data1", 64'(FWD_DATA1_SW), 64'h2);
        check("t3_hit2",  64'(FWD_HIT2_SW),  64'd0);
        check("t3_data2", 64'(FWD_DATA2_SW), 64'd0);
        tick();
        DRAIN_EN_SD = 1'b1;
        mid();
        check("t3_drain1_data1", 64'(FWD_DATA1_SW), 64'h2);
        tick();
        DRAIN_EN_SD = 1'b0;
        mid();
        check("t3_after1_hit1",  64'(FWD_HIT1_SW),  64'd1);
        check("t3_after1_data1", 64'(FWD_DATA1_SW), 64'h2);
        tick();
        DRAIN_EN_SD = 1'b1;
        mid();
        check("t3_drain2_data1", 64'(FWD_DATA1_SW), 64'h2);
        tick();
        mid();
        check("t3_after2_hit1",  64'(FWD_HIT1_SW),  64'd0);
        check("t3_after2_data1", 64'(FWD_DATA1_SW), 64'd0);
        check("t3_after2_empty", 64'(EMPTY_SW),     64'd1);

        // Illegal addresses
        tick();
        RADR1_SD = 6'd0;
        RADR2_SD = 6'd32;
        offer(6'd0, 32'h5);
        mid();
        check("t4_adr0_ready", 64'(WB_READY_SW), 64'd1);
        check("t4_radr0_hit",  64'(FWD_HIT1_SW), 64'd0);
        check("t4_radr32_hit", 64'(FWD_HIT2_SW), 64'd0);
        tick();
        offer(6'd32, 32'h6);
        mid();
        check("t4_adr0_nodrop", 64'(DROP_ERR_SW), 64'd0);
        check("t4_adr0_empty",  64'(EMPTY_SW),    64'd1);
        check("t4_adr32_ready", 64'(WB_READY_SW), 64'd1);
        tick();
        idle();
        mid();
        check("t4_adr32_drop",  64'(DROP_ERR_SW), 64'd1);
        check("t4_adr32_empty", 64'(EMPTY_SW),    64'd1);
        check("t4_adr32_nowen", 64'(WENABLE_SW),  64'd0);
        tick();
        mid();
        check("t4_drop_one_cycle", 64'(DROP_ERR_SW), 64'd0);

        // Streaming with concurrent accept and drain, pointers wrap twice
        tick();
        DRAIN_EN_SD = 1'b1;
        RADR1_SD    = 6'd0;
        RADR2_SD    = 6'd0;
        for (int i = 1; i <= 10; i++) begin
            offer(ADR_W'(i), XLEN'(i));
            exp_q.push_back({ADR_W'(i), XLEN'(i)});
            mid();
            check("t5_ready", 64'(WB_READY_SW), 64'd1);
            if (i > 1) begin
                check("t5_stream_wadr", 64'(WADR_SW), 64'(i - 1));
            end
            tick();
        end
        idle();
        mid();
        check("t5_last_wen",  64'(WENABLE_SW), 64'd1);
        check("t5_last_wadr", 64'(WADR_SW),    64'd10);
        tick();
        mid();
        check("t5_empty", 64'(EMPTY_SW), 64'd1);

        // Reset mid-operation with a transfer offered in the reset cycle
        tick();
        DRAIN_EN_SD = 1'b0;
        RADR1_SD    = 6'd1;
        for (int i = 1; i <= 3; i++) begin
            offer(ADR_W'(i), XLEN'(32'hA0 + i));
            tick();
        end
        reset = 1'b1;
        offer(6'd9, 32'h99);
        mid();
        check("t6_pre_empty", 64'(EMPTY_SW),     64'd0);
        check("t6_pre_hit1",  64'(FWD_HIT1_SW),  64'd1);
        check("t6_pre_data1", 64'(FWD_DATA1_SW), 64'hA1);
        tick();
        reset = 1'b0;
        idle();
        DRAIN_EN_SD = 1'b1;
        RADR2_SD    = 6'd9;
        mid();
        check("t6_empty", 64'(EMPTY_SW),     64'd1);
        check("t6_wen",   64'(WENABLE_SW),   64'd0);
        check("t6_hit1",  64'(FWD_HIT1_SW),  64'd0);
        check("t6_data1", 64'(FWD_DATA1_SW), 64'd0);
        check("t6_hit2",  64'(FWD_HIT2_SW),  64'd0);
        check("t6_ready", 64'(WB_READY_SW),  64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            check("t6_stays_empty", 64'(EMPTY_SW), 64'd1);
        end

        // ---------------- report ----------------
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
